// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the multi-channel line memory arbiter.
//   state_e       : FSM state encoding (idle / wait / response)
//   Def*          : default geometry and latency
//   idx_w()       : width of an index into n items (minimum 1 bit)
// Optional feature macro: MEM_ARB_FIXED_PRIO_EN (see mem_arbiter_rr_arbiter).
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned DefNumCh  = 2;
    localparam int unsigned DefLineW  = 128;
    localparam int unsigned DefAddrW  = 26;
    localparam int unsigned DefDepth  = 1024;
    localparam int unsigned DefMemLat = 5;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bus between NumCh cache clients and the line memory arbiter.
//   req       : per-channel level request, held until ack
//   is_write  : per-channel 1 = write line, 0 = read line
//   addr      : packed line addresses, channel i at [i*AddrW +: AddrW]
//   wdata     : packed write lines, channel i at [i*LineW +: LineW]
//   rdata     : shared read line, valid with rd_ready
//   rd_ready  : one-hot single-cycle read completion
//   wr_ack    : one-hot single-cycle write completion
//   busy      : transaction in progress
// Modports: master (client side), slave (arbiter side).
interface mem_arbiter_if #(
    parameter int unsigned NumCh = mem_arbiter_pkg::DefNumCh,
    parameter int unsigned LineW = mem_arbiter_pkg::DefLineW,
    parameter int unsigned AddrW = mem_arbiter_pkg::DefAddrW
);

    logic [NumCh-1:0]       req;
    logic [NumCh-1:0]       is_write;
    logic [NumCh*AddrW-1:0] addr;
    logic [NumCh*LineW-1:0] wdata;
    logic [LineW-1:0]       rdata;
    logic [NumCh-1:0]       rd_ready;
    logic [NumCh-1:0]       wr_ack;
    logic                   busy;

    modport master (
        output req, is_write, addr, wdata,
        input  rdata, rd_ready, wr_ack, busy
    );

    modport slave (
        input  req, is_write, addr, wdata,
        output rdata, rd_ready, wr_ack, busy
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Request arbiter: request vector + last-winner pointer -> one-hot grant and winner index.
//   req_i  : per-channel requests
//   ptr_i  : last winner; search starts at ptr_i+1 (mod NumCh)
//   gnt_o  : one-hot grant (zero when no request)
//   idx_o  : winner index
//   vld_o  : some channel is requesting
// Macro MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, ptr_i ignored);
// default build is round-robin.
module mem_arbiter_rr_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NumCh = DefNumCh,
    parameter int unsigned ChW   = idx_w(NumCh)
) (
    input  logic [NumCh-1:0] req_i,
    input  logic [ChW-1:0]   ptr_i,
    output logic [NumCh-1:0] gnt_o,
    output logic [ChW-1:0]   idx_o,
    output logic             vld_o
);

    logic           found;
    logic [ChW-1:0] idx;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NumCh; i++) begin
            if (!found && req_i[i]) begin
                found = 1'b1;
                idx   = ChW'(i);
            end
        end
    end
`else
    // Rotate the search so the channel after the last winner is checked first.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NumCh; i++) begin
            if (!found && req_i[(32'(ptr_i) + i) % NumCh]) begin
                found = 1'b1;
                idx   = ChW'((32'(ptr_i) + i) % NumCh);
            end
        end
    end
`endif

    always_comb begin
        gnt_o = '0;
        if (found) begin
            gnt_o[idx] = 1'b1;
        end
    end

    assign idx_o = idx;
    assign vld_o = found;

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel line memory with request arbitration and modelled access latency.
// One transaction in flight at a time: grant in idle, MemLat wait cycles, one response cycle.
//   clk_i    : clock, rising edge
//   reset_ni : asynchronous active-low reset (array contents are not cleared)
//   bus_io   : mem_arbiter_if slave modport (requests in, rdata/acks/busy out)
// Macro MEM_ARB_FIXED_PRIO_EN: fixed priority arbitration instead of round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NumCh  = DefNumCh,
    parameter int unsigned LineW  = DefLineW,
    parameter int unsigned AddrW  = DefAddrW,
    parameter int unsigned Depth  = DefDepth,
    parameter int unsigned MemLat = DefMemLat
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    mem_arbiter_if.slave bus_io
);

    localparam int unsigned ChW  = idx_w(NumCh);
    localparam int unsigned IdxW = idx_w(Depth);
    localparam int unsigned CntW = idx_w(MemLat);

    localparam logic [CntW-1:0] CntInit = CntW'(MemLat - 1);
    localparam logic [ChW-1:0]  PtrInit = ChW'(NumCh - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [NumCh-1:0] gnt_q;
    logic             wr_q;
    logic [IdxW-1:0]  idx_q;
    logic [LineW-1:0] wdata_q;
    logic [LineW-1:0] rdata_q;
    logic [LineW-1:0] mem_q [Depth];

    logic [NumCh-1:0] arb_gnt;
    logic [ChW-1:0]   arb_idx;
    logic             arb_vld;
    logic [ChW-1:0]   rr_ptr;

    logic grant;
    logic access;

    assign grant  = (state_q == StIdle) && arb_vld;
    assign access = (state_q == StWait) && (cnt_q == '0);

    mem_arbiter_rr_arbiter #(
        .NumCh (NumCh),
        .ChW   (ChW)
    ) u_arb (
        .req_i (bus_io.req),
        .ptr_i (rr_ptr),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [ChW-1:0] rr_ptr_q;

    // Resetting to the last channel makes channel 0 the first winner.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_ptr_q <= PtrInit;
        end else if (grant) begin
            rr_ptr_q <= arb_idx;
        end
    end

    assign rr_ptr = rr_ptr_q;
`endif

    // State register and latched operands.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                gnt_q   <= arb_gnt;
                wr_q    <= bus_io.is_write[arb_idx];
                idx_q   <= bus_io.addr[arb_idx*AddrW +: IdxW];
                wdata_q <= bus_io.wdata[arb_idx*LineW +: LineW];
            end
            if (access && !wr_q) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    // The array has no reset; a reset drops state_q to idle so an aborted write never lands.
    always_ff @(posedge clk_i) begin
        if (access && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (arb_vld) begin
                    state_d = StWait;
                    cnt_d   = CntInit;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        bus_io.rd_ready = '0;
        bus_io.wr_ack   = '0;
        bus_io.busy     = (state_q != StIdle);
        if (state_q == StResp) begin
            if (wr_q) begin
                bus_io.wr_ack = gnt_q;
            end else begin
                bus_io.rd_ready = gnt_q;
            end
        end
    end

    assign bus_io.rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level reference (line map, last-winner pointer, fixed latency).
module tb_mem_arbiter;

    localparam int unsigned NCH = 2;
    localparam int unsigned LW  = 128;
    localparam int unsigned AW  = 26;
    localparam int unsigned DEP = 1024;
    localparam int unsigned LAT = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NumCh(NCH), .LineW(LW), .AddrW(AW)) bus ();

    mem_arbiter #(
        .NumCh  (NCH),
        .LineW  (LW),
        .AddrW  (AW),
        .Depth  (DEP),
        .MemLat (LAT)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus_io   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state.
    logic [LW-1:0] ref_mem [int];
    int            written[$];
    int            ref_last;
    logic [LW-1:0] ref_rdata;

    // Pending request per channel.
    bit            pend [NCH];
    bit            pw   [NCH];
    logic [AW-1:0] pa   [NCH];
    logic [LW-1:0] pd   [NCH];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            bus.req[c]               = pend[c];
            bus.is_write[c]          = pw[c];
            bus.addr[c*AW +: AW]     = pa[c];
            bus.wdata[c*LW +: LW]    = pd[c];
        end
    endtask

    task automatic set_req(input int c, input bit w, input logic [AW-1:0] a,
                           input logic [LW-1:0] d);
        pend[c] = 1'b1;
        pw[c]   = w;
        pa[c]   = a;
        pd[c]   = d;
    endtask

    task automatic rand_req(input int c);
        logic [LW-1:0] d;
        int            ix;
        d = {$urandom, $urandom, $urandom, $urandom};
        if (written.size() == 0 || $urandom_range(1, 0) == 1) begin
            set_req(c, 1'b1, AW'($urandom), d);
        end else begin
            ix = written[$urandom_range(written.size() - 1, 0)];
            // Random upper bits must not affect which line is accessed.
            set_req(c, 1'b0, AW'((($urandom >> 10) << 10) | ix), d);
        end
    endtask

    function automatic int pick();
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NCH; k++) if (pend[k]) return k;
`else
        for (int k = 1; k <= NCH; k++) if (pend[(ref_last + k) % NCH]) return (ref_last + k) % NCH;
`endif
        return 0;
    endfunction

    // Entered at a falling edge with the DUT idle and requests already driven;
    // returns at the falling edge inside the ack cycle.
    task automatic serve(input string tag, input bit scramble);
        int               w;
        int               n;
        int               idx;
        bit               got;
        logic [NCH-1:0]   exp_oh;
        chk({tag, ".idle_busy"}, LW'(bus.busy), LW'(0));
        w      = pick();
        idx    = int'(pa[w]) % DEP;
        exp_oh = NCH'(1) << w;
        @(posedge clk);
        ref_last = w;
        n   = 0;
        got = 1'b0;
        while (!got && n < 4 * LAT + 8) begin
            @(negedge clk);
            n++;
            if (scramble && n == 2) begin
                bus.addr[w*AW +: AW]  = AW'($urandom);
                bus.wdata[w*LW +: LW] = {$urandom, $urandom, $urandom, $urandom};
                bus.is_write[w]       = ~pw[w];
                for (int c = 0; c < NCH; c++) if (!pend[c]) bus.req[c] = 1'b1;
            end
            if (scramble && n == 3) begin
                for (int c = 0; c < NCH; c++) if (!pend[c]) bus.req[c] = 1'b0;
            end
            if ((bus.rd_ready | bus.wr_ack) != '0) got = 1'b1;
            else chk({tag, ".busy"}, LW'(bus.busy), LW'(1));
        end
        chk({tag, ".latency"}, LW'(n), LW'(LAT + 1));
        chk({tag, ".ack_busy"}, LW'(bus.busy), LW'(1));
        if (pw[w]) begin
            chk({tag, ".wr_ack"}, LW'(bus.wr_ack), LW'(exp_oh));
            chk({tag, ".no_rd_ready"}, LW'(bus.rd_ready), LW'(0));
            chk({tag, ".rdata_held"}, bus.rdata, ref_rdata);
            ref_mem[idx] = pd[w];
            written.push_back(idx);
        end else begin
            chk({tag, ".rd_ready"}, LW'(bus.rd_ready), LW'(exp_oh));
            chk({tag, ".no_wr_ack"}, LW'(bus.wr_ack), LW'(0));
            ref_rdata = ref_mem[idx];
            chk({tag, ".rdata"}, bus.rdata, ref_rdata);
        end
        pend[w] = 1'b0;
    endtask

    // Next transaction after a previous ack: requests change on the falling edge of the
    // ack cycle, the following idle cycle samples them.
    task automatic go(input string tag, input bit scramble);
        drive();
        @(negedge clk);
        serve(tag, scramble);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] acc;
        logic [LW-1:0] old9;
        for (int c = 0; c < NCH; c++) begin
            pend[c] = 1'b0;
            pw[c]   = 1'b0;
            pa[c]   = '0;
            pd[c]   = '0;
        end
        drive();
        ref_last  = NCH - 1;
        ref_rdata = '0;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.busy", LW'(bus.busy), LW'(0));
        chk("reset.rd_ready", LW'(bus.rd_ready), LW'(0));
        chk("reset.wr_ack", LW'(bus.wr_ack), LW'(0));
        chk("reset.rdata", bus.rdata, LW'(0));
        rst_n = 1'b1;

        // Prefill line 3 and line 9, then single read of line 3.
        set_req(0, 1'b1, AW'(3), {16{8'hA5}});
        drive();
        serve("fill3", 1'b0);
        set_req(1, 1'b1, AW'(9), {4{32'h0BAD_F00D}});
        go("fill9", 1'b0);
        set_req(0, 1'b0, AW'(3), '0);
        go("read3", 1'b0);

        // Write then read of the same line.
        set_req(1, 1'b1, AW'(7), 128'hDEAD_C0DE_1234_5678_9ABC_DEF0_0BAD_BEEF);
        go("write7", 1'b0);
        set_req(0, 1'b0, AW'(7), '0);
        go("read7", 1'b0);

        // Address wrap: upper address bits are ignored.
        set_req(0, 1'b1, AW'(DEP + 2), {8{16'h5A3C}});
        go("write1026", 1'b0);
        set_req(1, 1'b0, AW'(2), '0);
        go("read2", 1'b0);

        // Contention with back-to-back re-requests from the served channel.
        rand_req(0);
        rand_req(1);
        for (int t = 0; t < 8; t++) begin
            go("contend", 1'b0);
            rand_req(ref_last);
        end

        // Randomized traffic with operand scrambling and ignored request pulses.
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NCH; c++) if (!pend[c] && $urandom_range(1, 0) == 1) rand_req(c);
            if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(NCH - 1, 0)));
            go("rand", 1'b1);
        end

        // Reset during the wait phase of a write to line 9.
        old9 = ref_mem[9];
        for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
        set_req(1, 1'b1, AW'(9), {$urandom, $urandom, $urandom, $urandom});
        drive();
        @(negedge clk);
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("abort.busy_before", LW'(bus.busy), LW'(1));
        rst_n = 1'b0;
        pend[1] = 1'b0;
        drive();
        #1;
        chk("abort.busy", LW'(bus.busy), LW'(0));
        chk("abort.rd_ready", LW'(bus.rd_ready), LW'(0));
        chk("abort.wr_ack", LW'(bus.wr_ack), LW'(0));
        chk("abort.rdata", bus.rdata, LW'(0));
        acc = '0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            acc = acc | LW'(bus.wr_ack) | LW'(bus.rd_ready);
        end
        chk("abort.no_ack", acc, LW'(0));
        rst_n     = 1'b1;
        ref_last  = NCH - 1;
        ref_rdata = '0;
        set_req(0, 1'b0, AW'(9), '0);
        drive();
        serve("abort.read9", 1'b0);
        chk("abort.old_line", ref_rdata, old9);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
